// File: rtl/call_responder.sv
// Two-argument method-call responder: request FIFO feeding a single registered result stage.
// Optional macro CALL_RESPONDER_SAT_EN switches sum_a/sum_b from modulo-256 wrap to saturating arithmetic.
module call_responder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sel,
    input  logic [7:0]       req_a1,
    input  logic [7:0]       req_a2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_sel,
    output logic [7:0]       rsp_ret,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic       sel;
        logic [7:0] a1;
        logic [7:0] a2;
    } call_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    call_t           mem [DEPTH];
    logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
    state_t          state_reg, state_next;
    logic            rsp_sel_reg;
    logic [7:0]      rsp_ret_reg;
    logic [CNT_W-1:0] cnt_a_reg, cnt_b_reg;

    logic            full, empty, push, pop, handshake;
    call_t           call_in, head;
    logic [8:0]      sum9, diff9;
    logic [7:0]      result;

    // Full when pointers match in index bits but differ in the wrap bit.
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    assign req_ready = !full;
    assign push      = req_valid && !full;

    assign call_in.sel = req_sel;
    assign call_in.a1  = req_a1;
    assign call_in.a2  = req_a2;

    // Head is read combinationally so a pop can compute and load in the same cycle.
    assign head = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= call_in;
        end
    end

    always_comb begin
        sum9  = {1'b0, head.a1} + {1'b0, head.a2};
        diff9 = {1'b0, head.a1} - {1'b0, head.a2};
`ifdef CALL_RESPONDER_SAT_EN
        if (head.sel) begin
            result = diff9[8] ? 8'h00 : diff9[7:0];
        end else begin
            result = sum9[8] ? 8'hFF : sum9[7:0];
        end
`else
        result = head.sel ? diff9[7:0] : sum9[7:0];
`endif
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    assign rsp_valid = (state_reg == ST_FULL);
    assign handshake = rsp_valid && rsp_ready;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            state_reg   <= ST_EMPTY;
            rsp_sel_reg <= 1'b0;
            rsp_ret_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
                rsp_sel_reg <= head.sel;
                rsp_ret_reg <= result;
            end
        end
    end

    // Per-method completion counters stick at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_reg <= '0;
            cnt_b_reg <= '0;
        end else if (handshake) begin
            if (!rsp_sel_reg && (cnt_a_reg != {CNT_W{1'b1}})) begin
                cnt_a_reg <= cnt_a_reg + 1'b1;
            end
            if (rsp_sel_reg && (cnt_b_reg != {CNT_W{1'b1}})) begin
                cnt_b_reg <= cnt_b_reg + 1'b1;
            end
        end
    end

    assign rsp_sel = rsp_sel_reg;
    assign rsp_ret = rsp_ret_reg;
    assign cnt_a   = cnt_a_reg;
    assign cnt_b   = cnt_b_reg;

endmodule

// File: tb/tb_call_responder.sv
// Directed self-checking bench for call_responder (counters built 4 bits wide to reach saturation).
module tb_call_responder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_sel = 1'b0;
    logic [7:0]       req_a1 = 8'd0;
    logic [7:0]       req_a2 = 8'd0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_sel;
    logic [7:0]       rsp_ret;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    call_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_a1    (req_a1),
        .req_a2    (req_a2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sel   (rsp_sel),
        .rsp_ret   (rsp_ret),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_call(input logic s, input logic [7:0] a1, input logic [7:0] a2);
        req_valid = 1'b1;
        req_sel   = s;
        req_a1    = a1;
        req_a2    = a2;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    // Issues one call with rsp_ready high and returns the result; bounded wait.
    task automatic send_call(input logic s, input logic [7:0] a1, input logic [7:0] a2,
                             output logic [7:0] ret, output logic got);
        got = 1'b0;
        ret = 8'h00;
        rsp_ready = 1'b1;
        drive_call(s, a1, a2);
        @(negedge clock);
        req_valid = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (rsp_valid) begin
                ret = rsp_ret;
                got = 1'b1;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_ret !== 8'd0 || rsp_sel !== 1'b0 ||
            cnt_a !== '0 || cnt_b !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: rsp_valid=%0d rsp_ret=%0d rsp_sel=%0d cnt_a=%0d cnt_b=%0d expected all 0",
                     rsp_valid, rsp_ret, rsp_sel, cnt_a, cnt_b);
        end
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_req_ready: got %0d expected 1", req_ready);
        end
        // One completed call so the counter has something to lose.
        rsp_ready = 1'b1;
        drive_call(1'b0, 8'd4, 8'd4);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++;
        if (cnt_a !== 4'd1) begin
            tests_failed++;
            $display("FAIL reset_precount: cnt_a got %0d expected 1", cnt_a);
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_call(1'b0, 8'd30 + 8'(i), 8'd1);
            @(negedge clock);
        end
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_queued: rsp_valid got %0d expected 1", rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_ret !== 8'd0 || cnt_a !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: rsp_valid=%0d rsp_ret=%0d cnt_a=%0d expected 0 0 0",
                     rsp_valid, rsp_ret, cnt_a);
        end
        @(negedge clock);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %0d expected 1", req_ready);
        end
        begin
            int stale;
            stale = 0;
            for (int c = 0; c < 6; c++) begin
                if (rsp_valid) stale++;
                @(negedge clock);
            end
            tests_run++;
            if (stale != 0 || cnt_a !== '0) begin
                tests_failed++;
                $display("FAIL reset_no_stale: stale results %0d cnt_a %0d expected 0 0", stale, cnt_a);
            end
        end
        $display("[TB] reset test done");
    endtask

    task automatic test_single();
        apply_reset();
        rsp_ready = 1'b1;
        drive_call(1'b0, 8'd1, 8'd2);
        @(negedge clock);
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latency: rsp_valid after accept edge got %0d expected 0", rsp_valid);
        end
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_ret !== 8'd3 || rsp_sel !== 1'b0 || cnt_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL single_result: valid=%0d ret=%0d sel=%0d cnt_a=%0d expected 1 3 0 0",
                     rsp_valid, rsp_ret, rsp_sel, cnt_a);
        end
        @(negedge clock);
        tests_run++;
        if (cnt_a !== 4'd1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_count: cnt_a=%0d rsp_valid=%0d expected 1 0", cnt_a, rsp_valid);
        end
        $display("[TB] single call 1+2 -> %0d", 3);
    endtask

    task automatic test_streaming();
        int k, first_j, last_j, ready_drops;
        k = 0; first_j = -1; last_j = -1; ready_drops = 0;
        apply_reset();
        rsp_ready = 1'b1;
        for (int j = 0; j < 14; j++) begin
            if (rsp_valid) begin
                tests_run++;
                if (rsp_ret !== 8'd7 + 8'(k) || rsp_sel !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stream_result[%0d]: ret=%0d sel=%0d expected %0d 1",
                             k, rsp_ret, rsp_sel, 7 + k);
                end
                if (first_j < 0) first_j = j;
                last_j = j;
                k++;
            end
            if (j < 8) begin
                if (req_ready !== 1'b1) ready_drops++;
                drive_call(1'b1, 8'd10 + 8'(j), 8'd3);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clock);
        end
        tests_run++;
        if (k != 8 || (last_j - first_j) != 7 || ready_drops != 0) begin
            tests_failed++;
            $display("FAIL stream_shape: results=%0d span=%0d ready_drops=%0d expected 8 7 0",
                     k, last_j - first_j, ready_drops);
        end
        tests_run++;
        if (cnt_b !== 4'd8 || cnt_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL stream_count: cnt_b=%0d cnt_a=%0d expected 8 0", cnt_b, cnt_a);
        end
        $display("[TB] streaming 8 subtract calls, results seen %0d", k);
    endtask

    task automatic test_backpressure();
        int k;
        apply_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (req_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_accept[%0d]: req_ready got %0d expected 1", i, req_ready);
            end
            drive_call(1'b0, 8'd20 + 8'(i), 8'(i));
            @(negedge clock);
        end
        req_valid = 1'b0;
        tests_run++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_ret !== 8'd20) begin
            tests_failed++;
            $display("FAIL bp_full: req_ready=%0d rsp_valid=%0d ret=%0d expected 0 1 20",
                     req_ready, rsp_valid, rsp_ret);
        end
        repeat (3) @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b0 || rsp_ret !== 8'd20 || cnt_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL bp_hold: req_ready=%0d ret=%0d cnt_a=%0d expected 0 20 0",
                     req_ready, rsp_ret, cnt_a);
        end
        rsp_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            if (rsp_valid) begin
                tests_run++;
                if (rsp_ret !== 8'd20 + 8'(2 * k)) begin
                    tests_failed++;
                    $display("FAIL bp_drain[%0d]: ret=%0d expected %0d", k, rsp_ret, 20 + 2 * k);
                end
                k++;
            end
            @(negedge clock);
        end
        tests_run++;
        if (k != 5 || cnt_a !== 4'd5 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain_count: results=%0d cnt_a=%0d rsp_valid=%0d expected 5 5 0",
                     k, cnt_a, rsp_valid);
        end
        $display("[TB] backpressure drained %0d results", k);
    endtask

    task automatic test_full_pop();
        int k;
        logic [7:0] got [8];
        logic [7:0] exp_seq [6];
        exp_seq[0] = 8'd49; exp_seq[1] = 8'd50; exp_seq[2] = 8'd51;
        exp_seq[3] = 8'd52; exp_seq[4] = 8'd53; exp_seq[5] = 8'd15;
        apply_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_call(1'b1, 8'd50 + 8'(i), 8'd1);
            @(negedge clock);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 15; c++) begin
            if (c == 0) begin
                tests_run++;
                if (req_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fullpop_blocked: req_ready got %0d expected 0", req_ready);
                end
            end
            if (c == 1) begin
                tests_run++;
                if (req_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL fullpop_reopen: req_ready got %0d expected 1", req_ready);
                end
            end
            if (c < 2) drive_call(1'b0, 8'd7, 8'd8);
            else       req_valid = 1'b0;
            if (rsp_valid) begin
                if (k < 8) got[k] = rsp_ret;
                k++;
            end
            @(negedge clock);
        end
        tests_run++;
        if (k != 6) begin
            tests_failed++;
            $display("FAIL fullpop_count: results=%0d expected 6", k);
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (got[i] !== exp_seq[i]) begin
                    tests_failed++;
                    $display("FAIL fullpop_order[%0d]: ret=%0d expected %0d", i, got[i], exp_seq[i]);
                end
            end
        end
        tests_run++;
        if (cnt_b !== 4'd5 || cnt_a !== 4'd1) begin
            tests_failed++;
            $display("FAIL fullpop_counters: cnt_a=%0d cnt_b=%0d expected 1 5", cnt_a, cnt_b);
        end
        $display("[TB] full-with-pop scenario returned %0d results", k);
    endtask

    task automatic test_wrap();
        logic [7:0] ret;
        logic got;
        logic [7:0] exp_add, exp_sub, exp_add_edge;
`ifdef CALL_RESPONDER_SAT_EN
        exp_add = 8'd255; exp_sub = 8'd0; exp_add_edge = 8'd255;
`else
        exp_add = 8'd44;  exp_sub = 8'd254; exp_add_edge = 8'd0;
`endif
        apply_reset();
        send_call(1'b0, 8'd200, 8'd100, ret, got);
        tests_run++;
        if (!got || ret !== exp_add) begin
            tests_failed++;
            $display("FAIL wrap_add: got_rsp=%0d ret=%0d expected %0d", got, ret, exp_add);
        end
        send_call(1'b1, 8'd3, 8'd5, ret, got);
        tests_run++;
        if (!got || ret !== exp_sub) begin
            tests_failed++;
            $display("FAIL wrap_sub: got_rsp=%0d ret=%0d expected %0d", got, ret, exp_sub);
        end
        send_call(1'b0, 8'd255, 8'd1, ret, got);
        tests_run++;
        if (!got || ret !== exp_add_edge) begin
            tests_failed++;
            $display("FAIL wrap_add_edge: got_rsp=%0d ret=%0d expected %0d", got, ret, exp_add_edge);
        end
        send_call(1'b1, 8'd5, 8'd5, ret, got);
        tests_run++;
        if (!got || ret !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_sub_zero: got_rsp=%0d ret=%0d expected 0", got, ret);
        end
        send_call(1'b0, 8'd254, 8'd1, ret, got);
        tests_run++;
        if (!got || ret !== 8'd255) begin
            tests_failed++;
            $display("FAIL wrap_add_max: got_rsp=%0d ret=%0d expected 255", got, ret);
        end
        tests_run++;
        if (cnt_a !== 4'd3 || cnt_b !== 4'd2) begin
            tests_failed++;
            $display("FAIL wrap_counters: cnt_a=%0d cnt_b=%0d expected 3 2", cnt_a, cnt_b);
        end
        $display("[TB] wrap/saturate arithmetic checks done");
    endtask

    task automatic test_saturate();
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_call(1'b0, 8'(i), 8'd0);
            @(negedge clock);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clock);
        tests_run++;
        if (cnt_a !== 4'd15 || cnt_b !== 4'd0) begin
            tests_failed++;
            $display("FAIL cnt_saturate: cnt_a=%0d cnt_b=%0d expected 15 0", cnt_a, cnt_b);
        end
        $display("[TB] 17 sum_a calls, cnt_a=%0d", cnt_a);
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/call_responder.md
Name: call_responder

Overview:
- Responder end of the two-argument method-call interface: callers issue a call (method select plus two 8-bit arguments) and the block returns the result.
- The call interface is decoupled into a valid/ready request channel and a valid/ready response channel, with a request FIFO and a registered result stage in between.
- Serves as the shared, multi-caller-safe backend for arithmetic helper calls. Callers no longer bind combinational argument ports directly.

Parameters:
DEPTH, 4, request FIFO entries; power of two, minimum 2
CNT_W, 16, width of per-method call counters

Ports:
clock  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  caller presents a call
req_ready  output  1  FIFO can accept a call
req_sel  input  1  method select: 0 = sum_a (add), 1 = sum_b (subtract)
req_a1  input  8  first argument
req_a2  input  8  second argument
rsp_valid  output  1  result register holds an unconsumed result
rsp_ready  input  1  caller consumes result
rsp_sel  output  1  method select of the returned result
rsp_ret  output  8  result value
cnt_a  output  CNT_W  completed sum_a calls
cnt_b  output  CNT_W  completed sum_b calls

Behaviour:
- Reset: asserting rst_n low asynchronously clears FIFO pointers and count. It forces rsp_valid=0, rsp_sel=0, rsp_ret=0, cnt_a=0, cnt_b=0. req_ready is 1 one cycle after release. Reset mid-operation discards all queued and pending calls; no partial result survives.
- Request accept: a call is accepted on an edge where req_valid && req_ready. req_ready = !full and does not depend on pop or on rsp_ready. A full FIFO never accepts, even when a pop occurs the same cycle.
- FIFO: read/write pointers are log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH. The FIFO is full when the pointers differ only in the MSB and empty when they are equal. A simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.
- Result stage (single register, two states):
  - EMPTY: rsp_valid=0. If the FIFO is non-empty, pop the head, compute, load rsp_ret/rsp_sel, and go to FULL.
  - FULL: rsp_valid=1. If rsp_ready is 1 and the FIFO is non-empty, pop, compute, and reload; stay FULL (back-to-back, one result per cycle). If rsp_ready is 1 and the FIFO is empty, go to EMPTY. If rsp_ready is 0, hold rsp_ret/rsp_sel stable.
- Latency: a call accepted at edge N into an empty FIFO with an EMPTY result stage gives rsp_valid=1 after edge N+1. There is no combinational bypass from req to rsp.
- Arithmetic (default build):
  - sum_a: rsp_ret = (a1 + a2) mod 256.
  - sum_b: rsp_ret = (a1 - a2) mod 256.
- Counters: increment on a response handshake (rsp_valid && rsp_ready), selected by rsp_sel. They saturate at 2^CNT_W-1 and do not wrap.
- Ordering: results return strictly in acceptance order.

Optional Feature:
CALL_RESPONDER_SAT_EN
- Defined: sum_a saturates at 255 (carry-out forces 8'hFF) and sum_b floors at 0 (borrow forces 8'h00).
- Undefined: both methods use modulo-256 wrap as above. No other behaviour changes.

Test Plan:
- Reset with rst_n low mid-stream, 3 calls queued -> rsp_valid=0 immediately (asynchronous), counters 0, req_ready=1 after release, no stale results appear.
- Single call sel=0, a1=1, a2=2 at edge N, rsp_ready=1 -> rsp_valid at N+1, rsp_ret=3, rsp_sel=0; cnt_a=1 after the handshake edge.
- Streaming: 8 calls sel=1, a1=10+i, a2=3, rsp_ready held 1 -> rsp_ret=7+i in order, one per cycle, req_ready never drops; cnt_b=8.
- Backpressure: rsp_ready=0, push DEPTH+1=5 calls -> after 5 accepts (4 in FIFO, 1 in result reg) req_ready=0, rsp_ret stable. Release rsp_ready -> all 5 results drained in order.
- Wrap/saturate: sel=0, a1=200, a2=100 -> 44 (default) or 255 with CALL_RESPONDER_SAT_EN. sel=1, a1=3, a2=5 -> 254 (default) or 0 with the macro.
- Full with simultaneous rsp pop: FIFO full, rsp_ready=1, req_valid=1 -> call not accepted that cycle; it is accepted the following cycle once req_ready rises.
